// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: one load cycle, then N_ITER micro-rotations, then a done pulse.
// Define CORDIC_ROTATION_EN to add the mode/z_neg ports and rotation-mode direction control.
module cordic_iter_ctrl #(
  parameter int unsigned N_ITER = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             go,
  input  logic             y_neg,
`ifdef CORDIC_ROTATION_EN
  input  logic             mode,
  input  logic             z_neg,
`endif
  output logic             ld_sel,
  output logic             reg_en,
  output logic             yr_x,
  output logic             yr_y,
  output logic             yr_z,
  output logic [CNT_W-1:0] shift_amt,
  output logic [CNT_W-1:0] rom_addr,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CORDIC_ROTATION_EN
  logic mode_q;

  // Mode is latched on acceptance so a change mid-operation cannot flip direction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
    end else if (state_q == StIdle && go) begin
      mode_q <= mode;
    end
  end

  assign dir_sel = mode_q ? z_neg : ~y_neg;
`else
  assign dir_sel = ~y_neg;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (go) state_d = StLoad;
      StLoad: begin
        cnt_d   = '0;
        state_d = StIter;
      end
      StIter: begin
        // Counter holds at the last index so it never wraps.
        if (cnt_q == LastCnt) state_d = StDone;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld_sel    = 1'b0;
    reg_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    yr_x      = 1'b1;
    yr_y      = 1'b1;
    yr_z      = 1'b1;
    shift_amt = '0;
    rom_addr  = '0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        ld_sel = 1'b1;
        reg_en = 1'b1;
        busy   = 1'b1;
      end
      StIter: begin
        reg_en    = 1'b1;
        busy      = 1'b1;
        yr_x      = dir_sel;
        yr_y      = ~dir_sel;
        yr_z      = dir_sel;
        shift_amt = cnt_q;
        rom_addr  = cnt_q;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
